// File: rtl/cpu_regfile_pkg.sv
// Shared constants, types and sizing helpers for the CPU integer register array.
package cpu_regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [XLEN-1:0] reg_data_t;

  function automatic int reg_count(input int half_regfile);
    return (half_regfile != 0) ? 16 : 32;
  endfunction

  function automatic int reg_idx_w(input int half_regfile);
    return (half_regfile != 0) ? 4 : 5;
  endfunction

endpackage

// File: rtl/cpu_regfile_ram.sv
// Register storage with one write port and one or two read ports, async or registered reads.
// CPU_REGFILE_RESET_CLEAR_EN: async-read storage is reset to 0 when defined.
module cpu_regfile_ram
  import cpu_regfile_pkg::*;
#(
  parameter int p_depth      = 32,
  parameter int p_idx_w      = 5,
  parameter int p_read_ports = 2,
  parameter int p_sync_read  = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr_en,
  input  logic [p_idx_w-1:0] i_wr_addr,
  input  logic [XLEN-1:0]    i_wr_data,
  input  logic [p_idx_w-1:0] i_rd1_addr,
  output logic [XLEN-1:0]    o_rd1_data,
  input  logic [p_idx_w-1:0] i_rd2_addr,
  output logic [XLEN-1:0]    o_rd2_data
);

  reg_data_t mem [p_depth];
  logic      unused_rst;

  assign unused_rst = i_rst;

  if (p_sync_read == 0) begin : g_async_store
`ifdef CPU_REGFILE_RESET_CLEAR_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int i = 0; i < p_depth; i++) mem[i] <= '0;
      end else if (i_wr_en) begin
        mem[i_wr_addr] <= i_wr_data;
      end
    end
`else
    always_ff @(posedge i_clk) begin
      if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
    end
`endif
    assign o_rd1_data = mem[i_rd1_addr];
  end else begin : g_sync_store
    // NOTE: no reset on the array itself so it maps onto RAM; the clear sequence zeroes it instead.
    always_ff @(posedge i_clk) begin
      if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
    end
    // Write-first: a same-edge read of the written address returns the new data.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                                   o_rd1_data <= '0;
      else if (i_wr_en && i_wr_addr == i_rd1_addr) o_rd1_data <= i_wr_data;
      else                                         o_rd1_data <= mem[i_rd1_addr];
    end
  end

  if (p_read_ports == 2 && p_sync_read == 0) begin : g_rd2_async
    assign o_rd2_data = mem[i_rd2_addr];
  end else if (p_read_ports == 2) begin : g_rd2_sync
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                                   o_rd2_data <= '0;
      else if (i_wr_en && i_wr_addr == i_rd2_addr) o_rd2_data <= i_wr_data;
      else                                         o_rd2_data <= mem[i_rd2_addr];
    end
  end else begin : g_rd2_none
    logic unused_rd2;
    assign unused_rd2 = ^i_rd2_addr;
    assign o_rd2_data = '0;
  end

endmodule

// File: rtl/cpu_regfile_array.sv
// Integer register array: x0 masking, out-of-bounds detection, busy gating and post-reset clear.
// CPU_REGFILE_RESET_CLEAR_EN: enables reset of contents (async) or the clear sequence (sync).
module cpu_regfile_array
  import cpu_regfile_pkg::*;
#(
  parameter int p_half_regfile = 0,
  parameter int p_read_ports   = 2,
  parameter int p_sync_read    = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_busy,
  output logic        o_addr_oob,
  input  logic [4:0]  i_rd1_addr,
  output logic [31:0] o_rd1_data,
  input  logic [4:0]  i_rd2_addr,
  output logic [31:0] o_rd2_data,
  input  logic        i_wr_en,
  input  logic [4:0]  i_wr_addr,
  input  logic [31:0] i_wr_data
);

  localparam int N     = reg_count(p_half_regfile);
  localparam int IDX_W = reg_idx_w(p_half_regfile);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic             busy;
  logic [IDX_W-1:0] clr_idx;
  logic             rd1_oob, rd2_oob, wr_oob, wr_ok;
  logic             rd1_zero, rd2_zero, rd1_zero_eff, rd2_zero_eff;
  logic             ram_we;
  logic [IDX_W-1:0] ram_waddr;
  reg_data_t        ram_wdata, ram_rd1, ram_rd2;

  // Bit 4 only names a nonexistent register in the 16-entry configuration.
  assign rd1_oob    = (p_half_regfile != 0) && i_rd1_addr[4];
  assign rd2_oob    = (p_half_regfile != 0) && (p_read_ports == 2) && i_rd2_addr[4];
  assign wr_oob     = (p_half_regfile != 0) && i_wr_addr[4];
  assign o_addr_oob = rd1_oob | rd2_oob | (i_wr_en & wr_oob);

`ifdef CPU_REGFILE_RESET_CLEAR_EN
  if (p_sync_read != 0) begin : g_clear
    logic [0:0] state;
    // NOTE: every sequential assignment is non-blocking so all flops sample pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        state   <= ST_CLEAR;
        clr_idx <= IDX_W'(1);
      end else if (state == ST_CLEAR) begin
        if (clr_idx == LAST_IDX) state <= ST_IDLE;
        clr_idx <= clr_idx + 1'b1;
      end
    end
    assign busy = (state == ST_CLEAR);
  end else begin : g_no_clear
    assign busy    = 1'b0;
    assign clr_idx = '0;
  end
`else
  assign busy    = 1'b0;
  assign clr_idx = '0;
`endif

  assign o_busy    = busy;
  assign wr_ok     = i_wr_en && !busy && !wr_oob && (i_wr_addr != '0);
  assign ram_we    = busy | wr_ok;
  assign ram_waddr = busy ? clr_idx : i_wr_addr[IDX_W-1:0];
  assign ram_wdata = busy ? '0 : i_wr_data;

  cpu_regfile_ram #(
    .p_depth      (N),
    .p_idx_w      (IDX_W),
    .p_read_ports (p_read_ports),
    .p_sync_read  (p_sync_read)
  ) u_ram (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_en    (ram_we),
    .i_wr_addr  (ram_waddr),
    .i_wr_data  (ram_wdata),
    .i_rd1_addr (i_rd1_addr[IDX_W-1:0]),
    .o_rd1_data (ram_rd1),
    .i_rd2_addr (i_rd2_addr[IDX_W-1:0]),
    .o_rd2_data (ram_rd2)
  );

  assign rd1_zero = busy | rd1_oob | (i_rd1_addr == '0);
  assign rd2_zero = busy | rd2_oob | (i_rd2_addr == '0);

  // Registered reads need the mask aligned with the data it qualifies.
  if (p_sync_read != 0) begin : g_sync_mask
    logic rd1_zero_q, rd2_zero_q;
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        rd1_zero_q <= 1'b1;
        rd2_zero_q <= 1'b1;
      end else begin
        rd1_zero_q <= rd1_zero;
        rd2_zero_q <= rd2_zero;
      end
    end
    assign rd1_zero_eff = rd1_zero_q;
    assign rd2_zero_eff = rd2_zero_q;
  end else begin : g_async_mask
    assign rd1_zero_eff = rd1_zero;
    assign rd2_zero_eff = rd2_zero;
  end

  assign o_rd1_data = rd1_zero_eff ? '0 : ram_rd1;

  if (p_read_ports == 2) begin : g_rd2
    assign o_rd2_data = rd2_zero_eff ? '0 : ram_rd2;
  end else begin : g_rd2_tied
    logic unused_rd2;
    assign unused_rd2 = ^{i_rd2_addr, ram_rd2, rd2_zero_eff};
    assign o_rd2_data = '0;
  end

endmodule

// File: tb/tb_cpu_regfile_array.sv
// Bench for cpu_regfile_array: four configurations checked against an array-based reference model.
module tb_cpu_regfile_array;

`ifdef CPU_REGFILE_RESET_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif
  // 0: async/32/2p  1: sync/32/2p  2: async/16/2p  3: sync/32/1p
  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        rst      [ND];
  logic [4:0]  rd1_addr [ND];
  logic [4:0]  rd2_addr [ND];
  logic [4:0]  wr_addr  [ND];
  logic        wr_en    [ND];
  logic [31:0] wr_data  [ND];
  logic [31:0] rd1_data [ND];
  logic [31:0] rd2_data [ND];
  logic        busy     [ND];
  logic        oob      [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    cpu_regfile_array #(
      .p_half_regfile ((g == 2) ? 1 : 0),
      .p_read_ports   ((g == 3) ? 1 : 2),
      .p_sync_read    ((g == 1 || g == 3) ? 1 : 0)
    ) u_dut (
      .i_clk      (clk),
      .i_rst      (rst[g]),
      .o_busy     (busy[g]),
      .o_addr_oob (oob[g]),
      .i_rd1_addr (rd1_addr[g]),
      .o_rd1_data (rd1_data[g]),
      .i_rd2_addr (rd2_addr[g]),
      .o_rd2_data (rd2_data[g]),
      .i_wr_en    (wr_en[g]),
      .i_wr_addr  (wr_addr[g]),
      .i_wr_data  (wr_data[g])
    );
  end

  int tests = 0;
  int fails = 0;
  int busy_cnt [ND];

  // Reference model: register contents, which ones are defined, remaining clear writes, sync outputs.
  logic [31:0] m_mem   [ND][32];
  bit          m_known [ND][32];
  int          m_clear [ND];
  logic [31:0] m_q1 [ND], m_q2 [ND];
  bit          m_k1 [ND], m_k2 [ND];

  function automatic int nregs(input int d);  return (d == 2) ? 16 : 32; endfunction
  function automatic bit is_sync(input int d); return (d == 1 || d == 3); endfunction
  function automatic int nports(input int d); return (d == 3) ? 1 : 2;  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void mread(input int d, input logic [4:0] a,
                                output logic [31:0] v, output bit k);
    if (m_clear[d] > 0 || a == 5'd0 || int'(a) >= nregs(d)) begin
      v = '0; k = 1'b1;
    end else begin
      v = m_mem[d][a]; k = m_known[d][a];
    end
  endfunction

  task automatic model_reset(input int d);
    if (CLEAR_EN && is_sync(d)) m_clear[d] = nregs(d) - 1;
    else if (CLEAR_EN) begin
      for (int r = 0; r < 32; r++) begin
        m_mem[d][r] = '0; m_known[d][r] = 1'b1;
      end
    end
    m_q1[d] = '0; m_k1[d] = 1'b1;
    m_q2[d] = '0; m_k2[d] = 1'b1;
  endtask

  task automatic model_edge(input int d);
    logic [31:0] v;
    bit k, wok;
    int idx;
    if (rst[d]) begin
      model_reset(d);
      return;
    end
    wok = (m_clear[d] == 0) && wr_en[d] && (wr_addr[d] != 5'd0) && (int'(wr_addr[d]) < nregs(d));
    if (is_sync(d)) begin
      mread(d, rd1_addr[d], v, k);
      if (wok && wr_addr[d] == rd1_addr[d]) begin v = wr_data[d]; k = 1'b1; end
      m_q1[d] = v; m_k1[d] = k;
      if (nports(d) == 2) begin
        mread(d, rd2_addr[d], v, k);
        if (wok && wr_addr[d] == rd2_addr[d]) begin v = wr_data[d]; k = 1'b1; end
      end else begin
        v = '0; k = 1'b1;
      end
      m_q2[d] = v; m_k2[d] = k;
    end
    if (m_clear[d] > 0) begin
      idx = nregs(d) - m_clear[d];
      m_mem[d][idx] = '0; m_known[d][idx] = 1'b1;
      m_clear[d]--;
    end else if (wok) begin
      m_mem[d][wr_addr[d]] = wr_data[d]; m_known[d][wr_addr[d]] = 1'b1;
    end
  endtask

  task automatic comb_check(input int d);
    logic [31:0] v;
    bit k, exp_oob;
    exp_oob = (nregs(d) == 16) &&
              (rd1_addr[d][4] || (nports(d) == 2 && rd2_addr[d][4]) || (wr_en[d] && wr_addr[d][4]));
    check($sformatf("oob[%0d]", d), {31'd0, oob[d]}, {31'd0, exp_oob});
    check($sformatf("busy[%0d]", d), {31'd0, busy[d]}, {31'd0, m_clear[d] > 0});
    if (!is_sync(d)) begin
      mread(d, rd1_addr[d], v, k);
      if (k) check($sformatf("rd1[%0d]", d), rd1_data[d], v);
      mread(d, rd2_addr[d], v, k);
      if (k) check($sformatf("rd2[%0d]", d), rd2_data[d], v);
    end
  endtask

  task automatic tick();
    #1;
    for (int d = 0; d < ND; d++) begin
      comb_check(d);
      if (busy[d] === 1'b1) busy_cnt[d]++;
    end
    @(posedge clk);
    for (int d = 0; d < ND; d++) model_edge(d);
    #1;
    for (int d = 0; d < ND; d++) begin
      if (is_sync(d)) begin
        if (m_k1[d]) check($sformatf("srd1[%0d]", d), rd1_data[d], m_q1[d]);
        if (m_k2[d]) check($sformatf("srd2[%0d]", d), rd2_data[d], m_q2[d]);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int d = 0; d < ND; d++) begin
      rd1_addr[d] = '0; rd2_addr[d] = '0;
      wr_en[d] = 1'b0; wr_addr[d] = '0; wr_data[d] = '0;
    end
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      rst[d] = 1'b1; busy_cnt[d] = 0; m_clear[d] = 0;
      for (int r = 0; r < 32; r++) m_known[d][r] = 1'b0;
      model_reset(d);
    end
    idle_all();
    repeat (2) tick();

    // Reset release, clear sequences, busy-time write, and a mid-clear reset on the 1-port DUT.
    for (int d = 0; d < ND; d++) begin rst[d] = 1'b0; busy_cnt[d] = 0; end
    for (int c = 0; c < 45; c++) begin
      idle_all();
      if (c == 0) begin wr_en[0] = 1'b1; wr_addr[0] = 5'd1; wr_data[0] = 32'd1; end
      if (c == 1) begin
        rd1_addr[0] = 5'd1;
        #1 check("a32_x1_after_reset", rd1_data[0], 32'd1);
      end
      if (c == 3) begin wr_en[1] = 1'b1; wr_addr[1] = 5'd4; wr_data[1] = 32'h0BAD_F00D; end
      if (c == 10) begin rst[3] = 1'b1; model_reset(3); end
      if (c == 11) begin rst[3] = 1'b0; busy_cnt[3] = 0; end
      tick();
    end
    check("s32_busy_cycles", busy_cnt[1], CLEAR_EN ? 32'd31 : 32'd0);
    check("s1_restart_busy_cycles", busy_cnt[3], CLEAR_EN ? 32'd31 : 32'd0);

    for (int a = 0; a < 32; a++) begin
      idle_all();
      rd1_addr[0] = 5'(a); rd1_addr[1] = 5'(a); rd2_addr[1] = 5'(31 - a);
      rd1_addr[2] = 5'(a); rd1_addr[3] = 5'(a); rd2_addr[3] = 5'(a);
      tick();
    end
    idle_all(); rd1_addr[1] = 5'd4; tick();
    check("s32_busy_write_ignored", rd1_data[1], CLEAR_EN ? 32'd0 : 32'h0BAD_F00D);

    // Async 32: write-then-read and x0 behaviour.
    idle_all(); wr_en[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEAD_BEEF; tick();
    idle_all(); rd1_addr[0] = 5'd5; rd2_addr[0] = 5'd0;
    #1 check("a32_rd1_x5", rd1_data[0], 32'hDEAD_BEEF);
    check("a32_rd2_x0", rd2_data[0], 32'd0);
    tick();
    idle_all(); wr_en[0] = 1'b1; wr_addr[0] = 5'd0; wr_data[0] = 32'h0000_1234; tick();
    idle_all();
    #1 check("a32_x0_discard", rd1_data[0], 32'd0);
    tick();

    // Sync 2-port: write-first on the same edge, then a different address.
    idle_all(); wr_en[1] = 1'b1; wr_addr[1] = 5'd3; wr_data[1] = 32'd0; tick();
    idle_all(); wr_en[1] = 1'b1; wr_addr[1] = 5'd7; wr_data[1] = 32'hA5A5_A5A5; rd1_addr[1] = 5'd7;
    tick();
    check("s32_write_first", rd1_data[1], 32'hA5A5_A5A5);
    idle_all(); rd1_addr[1] = 5'd3; tick();
    check("s32_rd_x3", rd1_data[1], 32'd0);

    // 16-register configuration: out-of-bounds reads and writes.
    idle_all(); wr_en[2] = 1'b1; wr_addr[2] = 5'd4; wr_data[2] = 32'h4444_4444; tick();
    idle_all(); rd1_addr[2] = 5'd16;
    #1 check("h16_rd_oob", {31'd0, oob[2]}, 32'd1);
    check("h16_rd_oob_data", rd1_data[2], 32'd0);
    tick();
    idle_all(); wr_en[2] = 1'b1; wr_addr[2] = 5'd20; wr_data[2] = 32'hFFFF_FFFF;
    #1 check("h16_wr_oob", {31'd0, oob[2]}, 32'd1);
    tick();
    idle_all(); wr_addr[2] = 5'd20; rd1_addr[2] = 5'd4;
    #1 check("h16_wr_oob_idle", {31'd0, oob[2]}, 32'd0);
    check("h16_x4_unchanged", rd1_data[2], 32'h4444_4444);
    tick();

    // Randomized traffic on every configuration.
    repeat (400) begin
      for (int d = 0; d < ND; d++) begin
        rd1_addr[d] = 5'($urandom_range(0, 31));
        rd2_addr[d] = 5'($urandom_range(0, 31));
        wr_addr[d]  = 5'($urandom_range(0, 31));
        wr_en[d]    = 1'($urandom_range(0, 1));
        wr_data[d]  = $urandom;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
